// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: instruction FSM, register file, flagged ALU and circular write-back log.
// Optional macro SAT_ARITH_EN: ADD clamps to all-ones and SUB clamps to zero on carry/borrow.
module multicycle_datapath #(
    parameter int DW = 8,
    parameter int AW = 2,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    opcode,
    input  logic [AW-1:0] rx,
    input  logic [AW-1:0] ry,
    input  logic [DW-1:0] imm,
    output logic          done,
    output logic          err,
    output logic          zero_flag,
    output logic          carry_flag,
    output logic [DW-1:0] show_data,
    input  logic [LW-1:0] log_addr,
    output logic [DW-1:0] log_data,
    output logic [LW:0]   log_count
);
    localparam int NREG   = 2**AW;
    localparam int LDEPTH = 2**LW;

    localparam logic [3:0] OP_LOAD = 4'd0;
    localparam logic [3:0] OP_MOVE = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHOW = 4'd15;

    localparam logic [LW:0] LOG_FULL = (LW+1)'(LDEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDA  = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_XOR) || (op == OP_SHOW);
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [3:0]    op_r;
    logic [AW-1:0] rx_r;
    logic [AW-1:0] ry_r;
    logic [DW-1:0] imm_r;
    logic [DW-1:0] regs_r [NREG];
    logic [DW-1:0] a_r;
    logic [DW-1:0] g_r;
    logic          zero_r;
    logic          carry_r;
    logic [DW-1:0] show_r;
    logic          ready_r;
    logic          done_r;
    logic          err_r;
    logic [LW-1:0] wr_ptr_r;
    logic [LW:0]   count_r;
    logic [DW-1:0] log_mem_r [LDEPTH];

    logic          accept_s;
    logic [DW:0]   raw_s;
    logic [DW:0]   sat_s;
    logic          wr_en_s;
    logic [DW-1:0] wr_data_s;

    assign accept_s    = instr_valid && ready_r;
    assign instr_ready = ready_r;
    assign done        = done_r;
    assign err         = err_r;
    assign zero_flag   = zero_r;
    assign carry_flag  = carry_r;
    assign show_data   = show_r;
    assign log_count   = count_r;
    assign log_data    = log_mem_r[log_addr];

    // Next-state decode: ALU ops take the LDA/EXEC path, everything else goes straight to WB.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (is_alu(opcode)) begin
                        state_s = S_LDA;
                    end else begin
                        state_s = S_WB;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LDA:   state_s = S_EXEC;
            S_EXEC:  state_s = S_WB;
            S_WB:    state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register and registered handshake/completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == S_IDLE);
            done_r  <= (state_s == S_WB);
            err_r   <= (state_r == S_IDLE) && accept_s && !is_legal(opcode);
        end
    end

    // ALU at DW+1 bits; bit DW is ADD carry-out or SUB borrow.
    always_comb begin
        raw_s = {(DW+1){1'b0}};
        case (op_r)
            OP_ADD:  raw_s = {1'b0, a_r} + {1'b0, regs_r[ry_r]};
            OP_SUB:  raw_s = {1'b0, a_r} - {1'b0, regs_r[ry_r]};
            OP_AND:  raw_s = {1'b0, a_r & regs_r[ry_r]};
            OP_OR:   raw_s = {1'b0, a_r | regs_r[ry_r]};
            OP_XOR:  raw_s = {1'b0, a_r ^ regs_r[ry_r]};
            default: raw_s = {(DW+1){1'b0}};
        endcase
    end

`ifdef SAT_ARITH_EN
    // Saturation keeps the carry/borrow bit so the flag still reports the unclamped result.
    always_comb begin
        sat_s = raw_s;
        if (raw_s[DW] && (op_r == OP_ADD)) begin
            sat_s = {1'b1, {DW{1'b1}}};
        end else if (raw_s[DW] && (op_r == OP_SUB)) begin
            sat_s = {1'b1, {DW{1'b0}}};
        end else begin
            sat_s = raw_s;
        end
    end
`else
    assign sat_s = raw_s;
`endif

    // Write-back source select; illegal ops and SHOW never write.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = {DW{1'b0}};
        if (state_r == S_WB) begin
            wr_en_s = (op_r <= OP_XOR);
            case (op_r)
                OP_LOAD: wr_data_s = imm_r;
                OP_MOVE: wr_data_s = regs_r[ry_r];
                default: wr_data_s = g_r;
            endcase
        end else begin
            wr_en_s   = 1'b0;
            wr_data_s = {DW{1'b0}};
        end
    end

    // Instruction latch, operand A, result G, flags and SHOW capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= 4'd0;
            rx_r    <= {AW{1'b0}};
            ry_r    <= {AW{1'b0}};
            imm_r   <= {DW{1'b0}};
            a_r     <= {DW{1'b0}};
            g_r     <= {DW{1'b0}};
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
            show_r  <= {DW{1'b0}};
        end else begin
            if (accept_s) begin
                op_r  <= opcode;
                rx_r  <= rx;
                ry_r  <= ry;
                imm_r <= imm;
            end
            if (state_r == S_LDA) begin
                a_r <= regs_r[rx_r];
            end
            if (state_r == S_EXEC) begin
                g_r     <= sat_s[DW-1:0];
                zero_r  <= (sat_s[DW-1:0] == {DW{1'b0}});
                carry_r <= ((op_r == OP_ADD) || (op_r == OP_SUB)) ? sat_s[DW] : 1'b0;
            end
            if ((state_r == S_WB) && (op_r == OP_SHOW)) begin
                show_r <= regs_r[rx_r];
            end
        end
    end

    // Register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rx_r] <= wr_data_s;
        end
    end

    // Log write pointer and saturating occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {LW{1'b0}};
            count_r  <= {(LW+1){1'b0}};
        end else if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + LW'(1);
            if (count_r != LOG_FULL) begin
                count_r <= count_r + (LW+1)'(1);
            end
        end
    end

    // Log storage is not cleared; entries beyond log_count are don't-care.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            log_mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle datapath core: instruction FSM, register file, ALU with flags, and a circular write-back log.
- Sits between the switch/debounce front end and the seven-segment display drivers.
- Accepts one instruction per valid/ready handshake and executes LOAD/MOVE in 1 cycle and ALU ops in 3 cycles.
- Exposes a SHOW result and a log read port for display.

Parameters:
- DW, 8, data/register width in bits
- AW, 2, register address width; NREG = 2**AW registers
- LW, 4, log address width; log depth = 2**LW entries

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- instr_valid  in  1  instruction strobe
- instr_ready  out  1  high only in IDLE
- opcode  in  4  operation code
- rx  in  AW  destination / first-operand register
- ry  in  AW  second-operand register
- imm  in  DW  immediate for LOAD
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, concurrent with done, on illegal opcode
- zero_flag  out  1  last ALU result == 0
- carry_flag  out  1  ADD carry-out / SUB borrow
- show_data  out  DW  register value captured by SHOW
- log_addr  in  LW  log read index
- log_data  out  DW  combinational log[log_addr]
- log_count  out  LW+1  valid log entries, saturating at 2**LW

Behaviour:
- Opcodes:
  - 0 LOAD: R[rx] <= imm
  - 1 MOVE: R[rx] <= R[ry]
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: R[rx] <= R[rx] op R[ry]
  - 15 SHOW: show_data <= R[rx]
  - all others: illegal
- Instructions are latched on a clk edge where instr_valid && instr_ready. Latched fields are opcode, rx, ry, imm.
- instr_valid is ignored while busy; no queueing.
- States are IDLE, LDA, EXEC, WB.
- IDLE transitions on accept:
  - ALU op -> LDA.
  - Any other op -> WB.
- LDA: A <= R[rx]; next state EXEC.
- EXEC: G <= A op R[ry], computed at DW+1 bits; zero_flag and carry_flag update; next state WB.
- WB: done=1 for exactly this cycle; next state IDLE.
  - LOAD/MOVE write R[rx]; ALU ops write R[rx] <= G[DW-1:0]. The write takes effect at the end of WB.
  - SHOW: show_data captured.
  - Illegal: err=1; no register, flag, or log change.
- Latency, counted from the accept edge to the cycle done is high:
  - LOAD/MOVE/SHOW/illegal: 1 cycle.
  - ALU ops: 3 cycles.
  - instr_ready returns high the cycle after done.
- AND/OR/XOR: carry_flag <= 0; zero_flag updated.
- LOAD, MOVE, and SHOW do not touch flags.
- rx==ry is legal and uses the pre-op value for both operands (ADD R1,R1 doubles R1).
- SUB uses wrap-around modulo 2**DW; carry_flag=1 when R[ry] > A.
- Log:
  - Every register write in WB stores the written value at log[wr_ptr] and increments wr_ptr modulo 2**LW.
  - Writes overwrite the oldest entry after wrap.
  - log_count increments up to 2**LW, then holds.
- Reset values:
  - All registers, A, G, flags, show_data, wr_ptr, log_count = 0.
  - done=0, err=0; state IDLE, so instr_ready=1 during the cycle after reset.
  - Log contents need not be cleared; entries at index >= log_count are don't-care.
- Reset mid-instruction aborts the instruction: no write, no done, no log entry.

Optional Feature:
- Macro SAT_ARITH_EN.
- Defined: ADD clamps to 2**DW-1 and SUB clamps to 0 when carry/borrow occurs. carry_flag still reports the unclamped carry/borrow. zero_flag reflects the clamped result.
- Undefined: ADD/SUB wrap modulo 2**DW.

Test Plan:
- Reset, then LOAD R0=0x02, R1=0x05, R2=0x03, R3=0x08:
  - done occurs 1 cycle after each accept.
  - log_count=4; log[0..3]=02,05,03,08.
- MOVE R0<=R2, then ADD R0,R1:
  - R0=0x03, then R0=0x08.
  - ADD done 3 cycles after accept; zero_flag=0, carry_flag=0.
- SUB R3,R2 with R3=0x08, R2=0x03:
  - R3=0x05, carry_flag=0.
  - Then SUB R2,R3 -> R2=0xFE, carry_flag=1 (0x00 with SAT_ARITH_EN).
- LOAD R0=0xF0, R1=0x20, ADD R0,R1:
  - R0=0x10, carry_flag=1 (0xFF with SAT_ARITH_EN).
  - XOR R1,R1 -> R1=0, zero_flag=1, carry_flag=0.
- Opcode 0x9:
  - done and err pulse together 1 cycle after accept; registers and log unchanged.
  - instr_valid held high during an ADD's busy cycles is not accepted.
- 18 LOADs of values 1..18:
  - log_count=16, log[0]=17, log[1]=18, log[2]=3.
  - rst asserted in EXEC of an ADD: no done, destination register unchanged, instr_ready=1 during the cycle after reset.
